// File: rtl/ace_snoop_pkg.sv
// Shared definitions for the ACE snoop-response driver.
//   - CR and CD channel FSM state encodings
//   - CRRESP bit positions
//   - Default CD burst length
//   - Saturating adder for the dropped-launch counter
package ace_snoop_pkg;

    // CRRESP bit positions
    localparam int unsigned CRRESP_DATA_TRANSFER = 0;
    localparam int unsigned CRRESP_ERROR         = 1;
    localparam int unsigned CRRESP_PASS_DIRTY    = 2;
    localparam int unsigned CRRESP_IS_SHARED     = 3;
    localparam int unsigned CRRESP_WAS_UNIQUE    = 4;

    // One 64-byte line at 128 bits per beat
    localparam int unsigned CD_BEATS_DEFAULT = 4;

    typedef enum logic {
        CR_IDLE,
        CR_VALID
    } cr_state_e;

    typedef enum logic [1:0] {
        CD_IDLE,
        CD_BEAT,
        CD_WAIT_LAST,
        CD_LAST
    } cd_state_e;

    // Adds 0..2 drops to the counter, clamping at 255.
    function automatic logic [7:0] drop_cnt_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/ace_rise_detect.sv
// Registered rising-edge detector.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset (previous value clears to 0)
//   d_i    : level input
//   rise_o : high in any cycle where d_i is 1 and was 0 at the previous edge
// Because the history clears to 0, an input already high when reset releases
// reports a rise on the first clock.
module ace_rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= d_i;
        end
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/ace_snoop_resp_driver.sv
// ACE snoop-response driver: converts level-style response controls into
// handshaked ACE CR transfers and multi-beat CD bursts.
//   ace_aclk / ace_areset        : clock, asynchronous active-high reset
//   i_crvalid, i_crresp          : CR launch (rising edge) and response value
//   i_cdvalid, i_cdlast, i_rdata : CD launch (rising edge), final-beat permission, payload
//   crvalid/crresp/crready       : ACE CR channel
//   cdvalid/cddata/cdlast/cdready: ACE CD channel
//   o_cr_done / o_cd_done        : one-cycle completion pulses
//   o_busy                       : either FSM not idle
//   o_drop_cnt                   : saturating count of dropped launches
module ace_snoop_resp_driver
    import ace_snoop_pkg::*;
#(
    parameter int unsigned C_ACE_DATA_WIDTH = 128,
    parameter int unsigned CD_BEATS         = CD_BEATS_DEFAULT
) (
    input  logic                        ace_aclk,
    input  logic                        ace_areset,

    input  logic                        i_crvalid,
    input  logic [4:0]                  i_crresp,
    input  logic                        i_cdvalid,
    input  logic                        i_cdlast,
    input  logic [C_ACE_DATA_WIDTH-1:0] i_rdata,

    output logic                        crvalid,
    output logic [4:0]                  crresp,
    input  logic                        crready,

    output logic                        cdvalid,
    output logic [C_ACE_DATA_WIDTH-1:0] cddata,
    output logic                        cdlast,
    input  logic                        cdready,

    output logic                        o_cr_done,
    output logic                        o_cd_done,
    output logic                        o_busy,
    output logic [7:0]                  o_drop_cnt
);

    localparam int unsigned BeatW = $clog2(CD_BEATS) + 1;
    // Index of the last beat issued from CD_BEAT (the final beat comes from CD_LAST)
    localparam logic [BeatW-1:0] LastBodyBeat =
        (CD_BEATS >= 2) ? BeatW'(CD_BEATS - 2) : '0;

    logic cr_rise;
    logic cd_rise;

    ace_rise_detect u_cr_rise (
        .clk_i  (ace_aclk),
        .rst_i  (ace_areset),
        .d_i    (i_crvalid),
        .rise_o (cr_rise)
    );

    ace_rise_detect u_cd_rise (
        .clk_i  (ace_aclk),
        .rst_i  (ace_areset),
        .d_i    (i_cdvalid),
        .rise_o (cd_rise)
    );

    cr_state_e                   cr_q, cr_d;
    logic [4:0]                  crresp_q, crresp_d;
    logic                        cr_done_q, cr_done_d;
    logic                        cr_drop;

    cd_state_e                   cd_q, cd_d;
    logic [C_ACE_DATA_WIDTH-1:0] data_q, data_d;
    logic [BeatW-1:0]            beat_q, beat_d;
    logic                        cd_done_q, cd_done_d;
    logic                        cd_drop;

    logic                        busy_q, busy_d;
    logic [7:0]                  drop_q, drop_d;

    // CR channel
    always_comb begin
        cr_d      = cr_q;
        crresp_d  = crresp_q;
        cr_done_d = 1'b0;
        cr_drop   = 1'b0;
        unique case (cr_q)
            CR_IDLE: begin
                if (cr_rise) begin
                    crresp_d = i_crresp;
                    cr_d     = CR_VALID;
                end
            end
            CR_VALID: begin
                // A rise during the completing cycle is still dropped
                cr_drop = cr_rise;
                if (crready) begin
                    cr_d      = CR_IDLE;
                    cr_done_d = 1'b1;
                end
            end
            default: cr_d = CR_IDLE;
        endcase
    end

    // CD channel
    always_comb begin
        cd_d      = cd_q;
        data_d    = data_q;
        beat_d    = beat_q;
        cd_done_d = 1'b0;
        cd_drop   = 1'b0;
        unique case (cd_q)
            CD_IDLE: begin
                if (cd_rise) begin
                    if (i_crresp[CRRESP_DATA_TRANSFER]) begin
                        data_d = i_rdata;
                        beat_d = '0;
                        if (CD_BEATS > 1) begin
                            cd_d = CD_BEAT;
                        end else if (i_cdlast) begin
                            cd_d = CD_LAST;
                        end else begin
                            cd_d = CD_WAIT_LAST;
                        end
                    end else begin
                        cd_drop = 1'b1;
                    end
                end
            end
            CD_BEAT: begin
                cd_drop = cd_rise;
                if (cdready) begin
                    beat_d = beat_q + 1'b1;
                    // Skip the wait state when permission is already present,
                    // keeping the burst free of bubbles.
                    if (beat_q == LastBodyBeat) begin
                        if (i_cdlast) begin
                            cd_d = CD_LAST;
                        end else begin
                            cd_d = CD_WAIT_LAST;
                        end
                    end
                end
            end
            CD_WAIT_LAST: begin
                cd_drop = cd_rise;
                if (i_cdlast) begin
                    cd_d = CD_LAST;
                end
            end
            CD_LAST: begin
                cd_drop = cd_rise;
                if (cdready) begin
                    cd_d      = CD_IDLE;
                    cd_done_d = 1'b1;
                end
            end
            default: cd_d = CD_IDLE;
        endcase
    end

    always_comb begin
        busy_d = (cr_d != CR_IDLE) || (cd_d != CD_IDLE);
        drop_d = drop_cnt_add(drop_q, {1'b0, cr_drop} + {1'b0, cd_drop});
    end

    always_ff @(posedge ace_aclk or posedge ace_areset) begin
        if (ace_areset) begin
            cr_q      <= CR_IDLE;
            crresp_q  <= '0;
            cr_done_q <= 1'b0;
            cd_q      <= CD_IDLE;
            data_q    <= '0;
            beat_q    <= '0;
            cd_done_q <= 1'b0;
            busy_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            cr_q      <= cr_d;
            crresp_q  <= crresp_d;
            cr_done_q <= cr_done_d;
            cd_q      <= cd_d;
            data_q    <= data_d;
            beat_q    <= beat_d;
            cd_done_q <= cd_done_d;
            busy_q    <= busy_d;
            drop_q    <= drop_d;
        end
    end

    assign crvalid    = (cr_q == CR_VALID);
    assign crresp     = crresp_q;
    assign cdvalid    = (cd_q == CD_BEAT) || (cd_q == CD_LAST);
    assign cdlast     = (cd_q == CD_LAST);
    assign cddata     = data_q;
    assign o_cr_done  = cr_done_q;
    assign o_cd_done  = cd_done_q;
    assign o_busy     = busy_q;
    assign o_drop_cnt = drop_q;

endmodule

// File: tb/tb_ace_snoop_resp_driver.sv
// Directed bench for ace_snoop_resp_driver. Inputs change and outputs are
// sampled on the falling edge; the DUT acts on the rising edge.
module tb_ace_snoop_resp_driver;

    logic         ace_aclk = 1'b0;
    logic         ace_areset;
    logic         i_crvalid, i_cdvalid, i_cdlast;
    logic [4:0]   i_crresp;
    logic [127:0] i_rdata;
    logic         crvalid, crready;
    logic [4:0]   crresp;
    logic         cdvalid, cdlast, cdready;
    logic [127:0] cddata;
    logic         o_cr_done, o_cd_done, o_busy;
    logic [7:0]   o_drop_cnt;

    int checks = 0;
    int errors = 0;
    int n_valid, n_done;

    always #5 ace_aclk = ~ace_aclk;

    ace_snoop_resp_driver #(
        .C_ACE_DATA_WIDTH (128),
        .CD_BEATS         (4)
    ) dut (
        .ace_aclk   (ace_aclk),
        .ace_areset (ace_areset),
        .i_crvalid  (i_crvalid),
        .i_crresp   (i_crresp),
        .i_cdvalid  (i_cdvalid),
        .i_cdlast   (i_cdlast),
        .i_rdata    (i_rdata),
        .crvalid    (crvalid),
        .crresp     (crresp),
        .crready    (crready),
        .cdvalid    (cdvalid),
        .cddata     (cddata),
        .cdlast     (cdlast),
        .cdready    (cdready),
        .o_cr_done  (o_cr_done),
        .o_cd_done  (o_cd_done),
        .o_busy     (o_busy),
        .o_drop_cnt (o_drop_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ace_aclk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " crvalid"}, 128'(crvalid), 128'd0);
        chk({tag, " cdvalid"}, 128'(cdvalid), 128'd0);
        chk({tag, " cdlast"}, 128'(cdlast), 128'd0);
        chk({tag, " crresp"}, 128'(crresp), 128'd0);
        chk({tag, " cddata"}, cddata, 128'd0);
        chk({tag, " busy"}, 128'(o_busy), 128'd0);
        chk({tag, " drop_cnt"}, 128'(o_drop_cnt), 128'd0);
        chk({tag, " cr_done"}, 128'(o_cr_done), 128'd0);
        chk({tag, " cd_done"}, 128'(o_cd_done), 128'd0);
    endtask

    // Checks a 4-beat burst starting at the current sample point, then the done pulse.
    task automatic check_burst(input string tag, input logic [127:0] data);
        for (int b = 1; b <= 4; b++) begin
            chk($sformatf("%s beat%0d cdvalid", tag, b), 128'(cdvalid), 128'd1);
            chk($sformatf("%s beat%0d cddata", tag, b), cddata, data);
            chk($sformatf("%s beat%0d cdlast", tag, b), 128'(cdlast), 128'(b == 4));
            step();
        end
        chk({tag, " end cdvalid"}, 128'(cdvalid), 128'd0);
        chk({tag, " cd_done"}, 128'(o_cd_done), 128'd1);
        step();
        chk({tag, " cd_done one pulse"}, 128'(o_cd_done), 128'd0);
    endtask

    initial begin
        ace_areset = 1'b1;
        i_crvalid  = 1'b0;
        i_cdvalid  = 1'b0;
        i_cdlast   = 1'b0;
        i_crresp   = 5'd0;
        i_rdata    = '0;
        crready    = 1'b0;
        cdready    = 1'b0;

        // Reset state
        step();
        check_idle_outputs("reset");
        ace_areset = 1'b0;
        step();

        // Single CR
        i_crresp  = 5'b00001;
        crready   = 1'b1;
        i_crvalid = 1'b1;
        step();
        chk("cr1 crvalid", 128'(crvalid), 128'd1);
        chk("cr1 crresp", 128'(crresp), 128'd1);
        chk("cr1 busy", 128'(o_busy), 128'd1);
        n_valid = 0;
        n_done  = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_valid += int'(crvalid);
            n_done  += int'(o_cr_done);
        end
        chk("cr1 extra valid cycles", 128'(n_valid), 128'd0);
        chk("cr1 done pulses", 128'(n_done), 128'd1);
        chk("cr1 busy after", 128'(o_busy), 128'd0);
        i_crvalid = 1'b0;
        step();

        // CR backpressure: input changes must not disturb the held response
        crready   = 1'b0;
        i_crresp  = 5'b10110;
        i_crvalid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            i_crresp = 5'b01001;
            chk($sformatf("crbp cyc%0d crvalid", i), 128'(crvalid), 128'd1);
            chk($sformatf("crbp cyc%0d crresp", i), 128'(crresp), 128'h16);
        end
        crready = 1'b1;
        step();
        chk("crbp crvalid after hs", 128'(crvalid), 128'd0);
        chk("crbp cr_done", 128'(o_cr_done), 128'd1);
        i_crvalid = 1'b0;
        crready   = 1'b0;
        step();

        // Full unbroken burst
        i_rdata   = 128'hFFFF0000;
        i_crresp  = 5'b00001;
        i_cdlast  = 1'b1;
        cdready   = 1'b1;
        i_cdvalid = 1'b1;
        step();
        check_burst("full", 128'hFFFF0000);
        chk("full cr untouched", 128'(crvalid), 128'd0);
        i_cdvalid = 1'b0;
        step();

        // Delayed last
        i_cdlast  = 1'b0;
        i_rdata   = 128'h1234_5678_9ABC_DEF0;
        i_cdvalid = 1'b1;
        for (int b = 1; b <= 3; b++) begin
            step();
            chk($sformatf("dly beat%0d cdvalid", b), 128'(cdvalid), 128'd1);
            chk($sformatf("dly beat%0d cdlast", b), 128'(cdlast), 128'd0);
        end
        n_valid = 0;
        for (int k = 4; k < 150; k++) begin
            step();
            n_valid += int'(cdvalid);
        end
        chk("dly no valid while waiting", 128'(n_valid), 128'd0);
        chk("dly busy while waiting", 128'(o_busy), 128'd1);
        i_cdlast = 1'b1;
        step();
        chk("dly last cdvalid", 128'(cdvalid), 128'd1);
        chk("dly last cdlast", 128'(cdlast), 128'd1);
        chk("dly last cddata", cddata, 128'h1234_5678_9ABC_DEF0);
        step();
        chk("dly end cdvalid", 128'(cdvalid), 128'd0);
        chk("dly cd_done", 128'(o_cd_done), 128'd1);
        i_cdvalid = 1'b0;
        step();
        chk("drop cnt before drops", 128'(o_drop_cnt), 128'd0);

        // Drop: CD launch without DataTransfer
        i_crresp  = 5'b00000;
        i_cdvalid = 1'b1;
        step();
        chk("drop1 cdvalid", 128'(cdvalid), 128'd0);
        chk("drop1 cnt", 128'(o_drop_cnt), 128'd1);
        i_cdvalid = 1'b0;
        step();

        // Drop: second CR rise while CR is stalled
        crready   = 1'b0;
        i_crvalid = 1'b1;
        step();
        chk("drop2 crvalid", 128'(crvalid), 128'd1);
        i_crvalid = 1'b0;
        step();
        i_crvalid = 1'b1;
        step();
        chk("drop2 cnt", 128'(o_drop_cnt), 128'd2);
        chk("drop2 crvalid held", 128'(crvalid), 128'd1);

        // Both rises dropped in one cycle count twice
        i_crvalid = 1'b0;
        step();
        i_crvalid = 1'b1;
        i_cdvalid = 1'b1;
        step();
        chk("drop both cnt", 128'(o_drop_cnt), 128'd4);

        // Saturation after 300 more double drops
        for (int i = 0; i < 300; i++) begin
            i_crvalid = 1'b0;
            i_cdvalid = 1'b0;
            step();
            i_crvalid = 1'b1;
            i_cdvalid = 1'b1;
            step();
        end
        chk("drop saturate", 128'(o_drop_cnt), 128'd255);
        i_crvalid = 1'b0;
        i_cdvalid = 1'b0;
        crready   = 1'b1;
        step();
        chk("drop stalled cr drains", 128'(crvalid), 128'd0);
        crready = 1'b0;
        step();

        // Reset mid-burst
        i_rdata   = 128'hA5A5_A5A5;
        i_crresp  = 5'b00001;
        i_cdlast  = 1'b1;
        cdready   = 1'b1;
        i_cdvalid = 1'b1;
        step();
        chk("rst beat1 cdvalid", 128'(cdvalid), 128'd1);
        step();
        chk("rst beat2 cdvalid", 128'(cdvalid), 128'd1);
        step();
        #2;
        ace_areset = 1'b1;
        #1;
        check_idle_outputs("rst async");
        step();
        step();
        ace_areset = 1'b0;
        step();
        check_burst("rst fresh", 128'hA5A5_A5A5);
        i_cdvalid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ace_snoop_resp_driver.md
# ace_snoop_resp_driver

Downstream stage of the snoop-response fault injector. It turns that block's level-style response controls (`crvalid`/`cdvalid`/`cdlast` flags and `crresp`/`rdata` values) into AXI-compliant ACE CR and CD channel transfers toward the interconnect. It enforces valid/ready stability, generates multi-beat CD bursts and counts dropped launch requests.

## Interface
- `C_ACE_DATA_WIDTH`, 128, CD data width.
- `CD_BEATS`, 4, beats per CD burst (one 64-byte line at 128 bits); legal range 1–16.
- `ace_aclk` in 1: sole clock.
- `ace_areset` in 1: reset, asynchronous and active-high.
- `i_crvalid` in 1: launch request for a CR transfer, level; its rising edge is the trigger.
- `i_crresp` in 5: CR response value; bit0 = DataTransfer.
- `i_cdvalid` in 1: launch request for a CD burst, level; its rising edge is the trigger.
- `i_cdlast` in 1: permission to present the final CD beat, level.
- `i_rdata` in C_ACE_DATA_WIDTH: CD payload.
- `crvalid` out 1, `crresp` out 5, `crready` in 1: ACE CR channel.
- `cdvalid` out 1, `cddata` out C_ACE_DATA_WIDTH, `cdlast` out 1, `cdready` in 1: ACE CD channel.
- `o_cr_done` out 1: one-cycle pulse on each CR handshake.
- `o_cd_done` out 1: one-cycle pulse on the final CD beat handshake.
- `o_busy` out 1: high when either channel FSM is not idle.
- `o_drop_cnt` out 8: count of dropped launches, saturating.

## Operation
- Edge detect: the registered previous values of `i_crvalid`/`i_cdvalid` reset to 0. A rise is `in & ~prev`. An input already high when reset releases therefore launches on the first clock.
- CR FSM, states CR_IDLE and CR_VALID:
  - A rise in CR_IDLE latches `i_crresp` and moves to CR_VALID.
  - In CR_VALID, `crvalid`=1.
  - On `crready`, the FSM returns to CR_IDLE and pulses `o_cr_done`.
- CD FSM, states CD_IDLE, CD_BEAT, CD_WAIT_LAST, CD_LAST:
  - A rise in CD_IDLE with `i_crresp[0]`=1 latches `i_rdata` and clears the beat counter.
  - It then enters CD_BEAT, or CD_WAIT_LAST when CD_BEATS=1.
  - If `i_crresp[0]`=0, the rise is dropped.
- CD_BEAT: `cdvalid`=1, `cdlast`=0. Each handshake increments the beat counter. After beat CD_BEATS-2 is accepted, the FSM goes to CD_WAIT_LAST.
- CD_WAIT_LAST: `cdvalid`=0. Once `i_cdlast`=1, the FSM goes to CD_LAST. It does not wait if `i_cdlast` is already high.
- CD_LAST: `cdvalid`=1, `cdlast`=1. On handshake the FSM returns to CD_IDLE and pulses `o_cd_done`.
- `cddata` equals the latched payload for every beat.
- Drop rule: a rise arriving while its FSM is not idle is dropped, including the cycle in which that FSM completes. Each dropped rise increments `o_drop_cnt`, which saturates at 255.
- When both rises drop in the same cycle, the counter increments by 2, still saturating.
- Beat counter width is $clog2(CD_BEATS)+1.

## Timing
- Reset values:
  - `crvalid`, `cdvalid`, `cdlast`, `o_cr_done`, `o_cd_done`, `o_busy` = 0.
  - `crresp` = 0, `cddata` = 0, `o_drop_cnt` = 0.
  - Both FSMs idle.
- Reset is asynchronous. Assertion mid-burst clears everything immediately, and no partial burst resumes.
- Latency: an input rise sampled at edge t gives valid high after edge t; the transfer is visible in cycle t+1.
- While valid && !ready, `crresp`/`cddata`/`cdlast` are held stable and valid is never withdrawn.
- Ready may be high before valid. A handshake completes at the first edge with valid && ready.
- Unbroken bursts: with `cdready` held at 1 and `i_cdlast` already high, a burst occupies exactly CD_BEATS consecutive valid cycles with no bubble. Entering CD_WAIT_LAST then costs no cycle.
- Otherwise, if `i_cdlast` rises at edge u, `cdvalid`/`cdlast` are high from cycle u+1.
- The CR and CD FSMs are independent; simultaneous rises launch both in the same cycle.
- `o_busy` is registered: it is high in any cycle where either FSM is not idle.

## Structure
- Shared package `ace_snoop_pkg` holds:
  - CR and CD FSM state encodings.
  - The CRRESP bit-position constants (DataTransfer=0, Error=1, PassDirty=2, IsShared=3, WasUnique=4).
  - The default CD_BEATS.
- Natural sub-module: `ace_rise_detect` (1-bit registered rising-edge detector with async active-high reset), instantiated twice.

## Test plan
- **Single CR:** `i_crresp`=5'b00001, `i_crvalid` rises, `crready`=1 → `crvalid` high for exactly 1 cycle starting one cycle after the rise, `crresp`=1, one `o_cr_done` pulse.
- **CR backpressure:** `crready` held 0 for 10 cycles → `crvalid` and `crresp` stable for 10 cycles, handshake on cycle 11.
- **Full burst:** `i_rdata`=128'hFFFF0000, `i_crresp[0]`=1, `i_cdlast`=1, `cdvalid` rises, `cdready`=1 → 4 consecutive beats of 0xFFFF0000 with `cdlast` only on beat 4, then one `o_cd_done` pulse.
- **Delayed last:** `i_cdlast` rises 150 cycles after `i_cdvalid` → 3 beats, then `cdvalid`=0 until the cycle after the `i_cdlast` rise, then a single beat with `cdlast`=1.
- **Drops:**
  - `i_cdvalid` rises with `i_crresp[0]`=0 → no CD activity, `o_drop_cnt`=1.
  - A second `i_crvalid` rise while CR is stalled → `o_drop_cnt`=2.
  - 300 dropped rises → `o_drop_cnt` saturates at 255.
- **Reset mid-burst:** assert `ace_areset` after beat 2 → all outputs 0 immediately. Release with `i_cdvalid` still high and `i_crresp[0]`=1 → a fresh 4-beat burst starts on the first clock.
